// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART 16750 constants: IIR codes and CTI timeout scaling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic [3:0] IIR_NONE = 4'b0001;
  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_CTI  = 4'b1100;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_THR  = 4'b0010;
  localparam logic [3:0] IIR_MSR  = 4'b0000;

  localparam int CTI_CHARS     = 4;
  localparam int TICKS_PER_BIT = 16;

  // Timeout in 16x ticks for a frame of char_bits bits
  function automatic logic [15:0] cti_limit(input logic [3:0] char_bits);
    return 16'(char_bits) * 16'(CTI_CHARS * TICKS_PER_BIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cti_timer.sv
// ============================================================================
// Module      : uart_cti_timer
// Description : Character-timeout counter; saturates at CHAR_BITS*64 ticks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cti_timer
  import uart_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BAUDCE,
  input  logic [3:0] CHAR_BITS,
  input  logic       RX_EMPTY,
  input  logic       RX_PUSH,
  input  logic       RX_POP,
  output logic       CTI
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cti_q, cti_d;
  logic [CNT_W-1:0] limit;
  logic             enabled;
  logic             clear;

  assign limit   = CNT_W'(cti_limit(CHAR_BITS));
  assign enabled = (CHAR_BITS != 4'd0);
  assign clear   = RX_EMPTY | RX_PUSH | RX_POP;

  always_comb begin
    cnt_d = cnt_q;
    cti_d = 1'b0;
    if (!enabled || clear) begin
      cnt_d = '0;
    end else begin
      if (BAUDCE && (cnt_q < limit)) begin
        cnt_d = cnt_q + 1'b1;
      end
      // >= so that a shrunk limit below the current count fires at once
      cti_d = (cnt_d >= limit);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      cti_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cti_q <= cti_d;
    end
  end

  assign CTI = cti_q;

endmodule

`default_nettype wire

// File: rtl/uart_int_ctrl.sv
// ============================================================================
// Module      : uart_int_ctrl
// Description : THR-empty interrupt latch and character-timeout indication.
//               CTI timer present only when UART_INT_CTRL_CTI_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_int_ctrl
  import uart_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BAUDCE,
  input  logic [3:0] CHAR_BITS,
  input  logic       IER_THRE,
  input  logic       IER_WE,
  input  logic       TX_EMPTY,
  input  logic       THR_WE,
  input  logic       RX_EMPTY,
  input  logic       RX_PUSH,
  input  logic       RX_POP,
  input  logic       IIR_RD,
  input  logic [3:0] IIR_ID,
  output logic       THI,
  output logic       CTI
);

  logic tx_empty_q, tx_empty_d;
  logic ier_thre_q, ier_thre_d;
  logic thi_q, thi_d;
  logic thi_set;

  // Written-value edge of IER[1] needs the previously written bit
  assign thi_set = (TX_EMPTY & ~tx_empty_q)
                 | (IER_WE & IER_THRE & ~ier_thre_q & TX_EMPTY);

  always_comb begin
    tx_empty_d = TX_EMPTY;
    ier_thre_d = IER_WE ? IER_THRE : ier_thre_q;
    thi_d      = thi_q;
    if (THR_WE) begin
      thi_d = 1'b0;
    end else if (thi_set) begin
      thi_d = 1'b1;
    end else if (IIR_RD && (IIR_ID == IIR_THR)) begin
      thi_d = 1'b0;
    end
  end

  // Edge register resets to 1 so an idle, empty THR gives no THI
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_empty_q <= 1'b1;
      ier_thre_q <= 1'b0;
      thi_q      <= 1'b0;
    end else begin
      tx_empty_q <= tx_empty_d;
      ier_thre_q <= ier_thre_d;
      thi_q      <= thi_d;
    end
  end

  assign THI = thi_q;

`ifdef UART_INT_CTRL_CTI_EN
  uart_cti_timer #(
    .CNT_W    (CNT_W)
  ) u_cti_timer (
    .CLK      (CLK),
    .RST      (RST),
    .BAUDCE   (BAUDCE),
    .CHAR_BITS(CHAR_BITS),
    .RX_EMPTY (RX_EMPTY),
    .RX_PUSH  (RX_PUSH),
    .RX_POP   (RX_POP),
    .CTI      (CTI)
  );
`else
  localparam int unused_cnt_w = CNT_W;
  logic unused_cti_inputs;
  assign unused_cti_inputs = ^{BAUDCE, CHAR_BITS, RX_EMPTY, RX_PUSH, RX_POP};
  assign CTI = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_int_ctrl.sv
// ============================================================================
// Module      : tb_uart_int_ctrl
// Description : Directed self-checking bench for uart_int_ctrl and its timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_int_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BAUDCE, IER_THRE, IER_WE, TX_EMPTY, THR_WE;
  logic       RX_EMPTY, RX_PUSH, RX_POP, IIR_RD;
  logic [3:0] CHAR_BITS, IIR_ID;
  logic       THI, CTI, tmr_cti;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  uart_int_ctrl #(.CNT_W(10)) dut (
    .CLK(CLK), .RST(RST), .BAUDCE(BAUDCE), .CHAR_BITS(CHAR_BITS),
    .IER_THRE(IER_THRE), .IER_WE(IER_WE), .TX_EMPTY(TX_EMPTY),
    .THR_WE(THR_WE), .RX_EMPTY(RX_EMPTY), .RX_PUSH(RX_PUSH),
    .RX_POP(RX_POP), .IIR_RD(IIR_RD), .IIR_ID(IIR_ID),
    .THI(THI), .CTI(CTI)
  );

  // Timer is also exercised standalone so it is covered in every build
  uart_cti_timer #(.CNT_W(10)) u_tmr (
    .CLK(CLK), .RST(RST), .BAUDCE(BAUDCE), .CHAR_BITS(CHAR_BITS),
    .RX_EMPTY(RX_EMPTY), .RX_PUSH(RX_PUSH), .RX_POP(RX_POP), .CTI(tmr_cti)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cti(input string tag, input logic exp);
    check({tag, "_tmr"}, 32'(tmr_cti), 32'(exp));
`ifdef UART_INT_CTRL_CTI_EN
    check({tag, "_top"}, 32'(CTI), 32'(exp));
`else
    check({tag, "_top_off"}, 32'(CTI), 32'd0);
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RST = 1'b1; BAUDCE = 1'b0; IER_THRE = 1'b0; IER_WE = 1'b0;
    TX_EMPTY = 1'b1; THR_WE = 1'b0; RX_EMPTY = 1'b1; RX_PUSH = 1'b0;
    RX_POP = 1'b0; IIR_RD = 1'b0; CHAR_BITS = 4'd10; IIR_ID = 4'b0001;
    tick(2);
    check("rst_thi", 32'(THI), 32'd0);
    check_cti("rst_cti", 1'b0);
    RST = 1'b0;
    tick(3);
    check("idle_empty_no_thi", 32'(THI), 32'd0);

    // THI set on TX_EMPTY rising edge
    TX_EMPTY = 1'b0; tick(1);
    check("tx_low", 32'(THI), 32'd0);
    TX_EMPTY = 1'b1; tick(1);
    check("tx_rise_set", 32'(THI), 32'd1);

    // IIR read clears only when the ID is the THR code
    IIR_RD = 1'b1; IIR_ID = 4'b0100; tick(1);
    check("iir_rda_keep", 32'(THI), 32'd1);
    IIR_ID = 4'b0010; tick(1);
    check("iir_thr_clr", 32'(THI), 32'd0);
    IIR_RD = 1'b0;

    // IER_THRE 0->1 with THR empty
    IER_WE = 1'b1; IER_THRE = 1'b1; tick(1);
    check("ier_set", 32'(THI), 32'd1);
    IER_WE = 1'b0;
    THR_WE = 1'b1; tick(1);
    check("thr_we_clr", 32'(THI), 32'd0);
    THR_WE = 1'b0;
    IER_WE = 1'b1; IER_THRE = 1'b1; tick(1);
    check("ier_1to1_noset", 32'(THI), 32'd0);
    IER_THRE = 1'b0; tick(1);
    IER_THRE = 1'b1; THR_WE = 1'b1; tick(1);
    check("thr_we_beats_ier", 32'(THI), 32'd0);
    IER_WE = 1'b0; THR_WE = 1'b0;

    // Set beats IIR clear in the same cycle; THI ignores later IER masking
    TX_EMPTY = 1'b0; tick(1);
    TX_EMPTY = 1'b1; IIR_RD = 1'b1; IIR_ID = 4'b0010; tick(1);
    check("set_beats_iir", 32'(THI), 32'd1);
    IIR_RD = 1'b0; IER_WE = 1'b1; IER_THRE = 1'b0; tick(1);
    check("thi_ignores_ier", 32'(THI), 32'd1);
    IER_WE = 1'b0;

    // CTI: 640 ticks at CHAR_BITS=10
    RX_EMPTY = 1'b0; BAUDCE = 1'b1;
    tick(639);
    check_cti("cti_639", 1'b0);
    tick(1);
    check_cti("cti_640", 1'b1);
    tick(5);
    check_cti("cti_sat_hold", 1'b1);
    IIR_RD = 1'b1; IIR_ID = 4'b1100; tick(1);
    check_cti("cti_iir_keep", 1'b1);
    IIR_RD = 1'b0;
    RX_POP = 1'b1; tick(1);
    check_cti("cti_pop_clr", 1'b0);
    RX_POP = 1'b0;
    tick(639);
    check_cti("cti_again_639", 1'b0);
    tick(1);
    check_cti("cti_again_640", 1'b1);
    RX_EMPTY = 1'b1; tick(1);
    check_cti("cti_rx_empty_clr", 1'b0);
    RX_EMPTY = 1'b0;

    // Gaps in BAUDCE stall the count
    BAUDCE = 1'b0; tick(700);
    check_cti("cti_no_baud", 1'b0);
    BAUDCE = 1'b1;

    // Limit shrink below current count fires on the next cycle
    RX_PUSH = 1'b1; tick(1);
    RX_PUSH = 1'b0;
    tick(500);
    BAUDCE = 1'b0; tick(1);
    check_cti("cti_at_500", 1'b0);
    CHAR_BITS = 4'd7; tick(1);
    check_cti("cti_limit_shrink", 1'b1);
    CHAR_BITS = 4'd0; BAUDCE = 1'b1; tick(1);
    check_cti("cti_disabled_now", 1'b0);
    tick(2000);
    check_cti("cti_disabled_2000", 1'b0);

    // Asynchronous reset mid-count
    CHAR_BITS = 4'd10;
    TX_EMPTY = 1'b0; tick(1);
    TX_EMPTY = 1'b1; tick(300);
    check("pre_rst_thi", 32'(THI), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_thi", 32'(THI), 32'd0);
    check_cti("async_rst_cti", 1'b0);
    tick(1);
    RST = 1'b0;
    tick(639);
    check("post_rst_thi", 32'(THI), 32'd0);
    check_cti("post_rst_639", 1'b0);
    tick(1);
    check_cti("post_rst_640", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_int_ctrl.md
# uart_int_ctrl

Interrupt-source sequencer for the UART 16750 interrupt path. It generates the two sourced interrupt conditions that need state, the THR-empty interrupt (THI) and the character-timeout indication (CTI), and clears them in response to host register accesses. Its outputs feed the THI and CTI inputs of the interrupt priority block.

## Interface
Parameters:
- CNT_W, default 10: width of the timeout counter. Must satisfy 2^CNT_W > 15*64.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- BAUDCE  in  1  16x baud tick, single-cycle strobe
- CHAR_BITS  in  4  total frame bits (start+data+parity+stop), nominally 7..12
- IER_THRE  in  1  IER[1], THR-empty interrupt enable
- IER_WE  in  1  host write strobe to IER
- TX_EMPTY  in  1  THR / TX FIFO empty level
- THR_WE  in  1  host write strobe to THR
- RX_EMPTY  in  1  RX FIFO empty level
- RX_PUSH  in  1  character pushed into RX FIFO
- RX_POP  in  1  host read of RBR (FIFO pop)
- IIR_RD  in  1  host read strobe of IIR
- IIR_ID  in  4  current IIR value presented to host
- THI  out  1  THR-empty interrupt pending
- CTI  out  1  character timeout pending

## Operation
THI latch:
- Set event: TX_EMPTY rises (0→1, registered edge detect), or IER_WE with IER_THRE written 0→1 while TX_EMPTY=1.
- Clear events: THR_WE, or IIR_RD with IIR_ID==4'b0010.
- Priority in one cycle: THR_WE clear, then set event, then IIR_RD clear. A set event and an IIR-read clear in the same cycle leave THI=1.
- THI does not depend on IER_THRE once set. Masking is done downstream.

CTI timer:
- Counter cnt (CNT_W bits). limit = CHAR_BITS*64, which equals 4 character times at 16 ticks per bit.
- cnt clears to 0 when RX_EMPTY=1, RX_PUSH=1 or RX_POP=1. These take priority over increment.
- Otherwise cnt increments on BAUDCE until it equals limit, then holds (saturates, no wrap).
- CTI=1 while cnt==limit and RX_EMPTY=0. CTI clears by the same events that clear cnt.
- IIR reads do not clear CTI.
- CHAR_BITS==0 disables the timer: CTI held 0 and cnt held 0.
- A CHAR_BITS change mid-count takes effect immediately. If cnt already exceeds the new limit, CTI asserts on the next cycle.

## Timing
- Reset values: THI=0, CTI=0, cnt=0, TX_EMPTY edge register=1 (no spurious THI after reset).
- All outputs are registered. THI and CTI change exactly 1 CLK after the causing input cycle.
- TX_EMPTY rising at cycle n gives THI=1 at n+1. THR_WE at cycle m gives THI=0 at m+1.
- BAUDCE that brings cnt to limit at cycle n gives CTI=1 at n+1.
- RST asserted mid-count aborts immediately and asynchronously to the reset values. The first count resumes on the first BAUDCE after release.
- Strobes are single-cycle. A strobe held for several cycles behaves as repeated strobes.

## Configuration
- Macro UART_INT_CTRL_CTI_EN:
  - Defined: CTI timer as specified.
  - Not defined: CTI tied to 0, counter and CHAR_BITS logic removed, and BAUDCE, RX_EMPTY, RX_PUSH, RX_POP and CHAR_BITS are unused. THI behaviour is unchanged.

## Structure
- Shared package uart_pkg holds:
  - IIR code constants: IIR_NONE=4'b0001, IIR_RLS=4'b0110, IIR_CTI=4'b1100, IIR_RDA=4'b0100, IIR_THR=4'b0010, IIR_MSR=4'b0000.
  - CTI_CHARS=4 and TICKS_PER_BIT=16, used to derive limit.
- One sub-module, uart_cti_timer, contains the counter, limit compare and CTI register. It is instantiated under UART_INT_CTRL_CTI_EN.

## Test plan
- Reset, then TX_EMPTY held 1 → THI stays 0. Drop TX_EMPTY to 0, raise it to 1 at cycle n → THI=1 at n+1.
- THI=1, IIR_RD with IIR_ID=4'b0010 → THI=0 next cycle. Repeat with IIR_ID=4'b0100 → THI stays 1.
- TX_EMPTY=1, IER_WE with IER_THRE 0→1 → THI=1. Same cycle also THR_WE=1 → THI=0.
- CHAR_BITS=10, RX_EMPTY=0, BAUDCE every cycle, no push/pop → CTI=1 after 640 ticks plus 1 cycle. One RX_POP then clears CTI, and a full 640 ticks are needed again.
- CHAR_BITS=10 with cnt=500, change CHAR_BITS to 7 (limit 448) → CTI=1 next cycle. CHAR_BITS=0 → CTI never asserts after 2000 ticks.
- Assert RST while cnt=300 and THI=1 → THI=0, CTI=0 immediately. After release the timer restarts from 0.
